// File: rtl/net_rx_pkg.sv
// Shared types and widths for the receive packet buffer: flit layout, write FSM
// states and a saturating counter helper.
package net_rx_pkg;

    localparam int NET_IF_WIDTH   = 64;
    localparam int NET_KEEP_WIDTH = 8;

    typedef enum logic {
        RECV = 1'b0,
        DROP = 1'b1
    } wr_state_t;

    typedef struct packed {
        logic [NET_KEEP_WIDTH-1:0] keep;
        logic [NET_IF_WIDTH-1:0]   data;
    } flit_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/net_rx_len_fifo.sv
// Small synchronous FIFO holding one length word per committed packet; the head
// entry is read asynchronously so it is usable in the same cycle.
module net_rx_len_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count != '0);
    assign head    = mem[rd_idx];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (pop_ok) begin
                rd_idx <= rd_idx + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/net_rx_packet_buffer.sv
// Receive packet buffer: absorbs a non-backpressured flit stream into a circular
// store and releases whole packets only; packets that do not fit are dropped.
module net_rx_packet_buffer
    import net_rx_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int MAX_PKTS = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [NET_IF_WIDTH-1:0]   in_data,
    input  logic [NET_KEEP_WIDTH-1:0] in_keep,
    input  logic                      in_last,
    output logic                      out_valid,
    output logic [NET_IF_WIDTH-1:0]   out_data,
    output logic [NET_KEEP_WIDTH-1:0] out_keep,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic [15:0]               drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_PKTS) + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    flit_t           mem [DEPTH];
    flit_t           head_flit;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   commit_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   cur_len;
    logic [PW-1:0]   rd_cnt;
    logic [PW-1:0]   used;
    logic [PW-1:0]   len_head;
    logic [PW-1:0]   push_len;
    logic [CW-1:0]   pkt_count;
    logic            len_full;
    wr_state_t       state;
    wr_state_t       state_next;
    logic            fits;
    logic            wr_en;
    logic            drop_now;
    logic            push;
    logic            rd_fire;
    logic            pop;

    // Space check uses start-of-cycle pointers only; a same-cycle read earns no credit.
    assign used     = wr_ptr - rd_ptr;
    assign fits     = (used < DEPTH_P) && !len_full;
    assign push     = wr_en && in_last;
    assign push_len = cur_len + 1'b1;

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        drop_now   = 1'b0;
        if (in_valid) begin
            case (state)
                RECV: begin
                    if (fits) begin
                        wr_en = 1'b1;
                    end else begin
                        drop_now = 1'b1;
                        if (!in_last) begin
                            state_next = DROP;
                        end
                    end
                end
                DROP: begin
                    if (in_last) begin
                        state_next = RECV;
                    end
                end
                default: state_next = RECV;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RECV;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {in_keep, in_data};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            cur_len    <= '0;
            drop_count <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (in_last) begin
                commit_ptr <= wr_ptr + 1'b1;
                cur_len    <= '0;
            end else begin
                cur_len <= push_len;
            end
        end else if (drop_now) begin
            // Discard the partial packet by rewinding to the last commit point.
            wr_ptr     <= commit_ptr;
            cur_len    <= '0;
            drop_count <= sat_inc16(drop_count);
        end
    end

    net_rx_len_fifo #(
        .WIDTH (PW),
        .DEPTH (MAX_PKTS)
    ) u_len_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_len),
        .pop       (pop),
        .head      (len_head),
        .count     (pkt_count),
        .full      (len_full)
    );

    assign head_flit = mem[rd_ptr[AW-1:0]];
    assign out_valid = (pkt_count != '0);
    assign out_data  = head_flit.data;
    assign out_keep  = head_flit.keep;
    // Gated by out_valid so a stale length entry never asserts out_last.
    assign out_last  = out_valid && (rd_cnt == len_head - 1'b1);
    assign rd_fire   = out_valid && out_ready;
    assign pop       = rd_fire && out_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            rd_cnt <= '0;
        end else if (rd_fire) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (out_last) begin
                rd_cnt <= '0;
            end else begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_net_rx_packet_buffer.sv
// Bench for net_rx_packet_buffer: table of packet scenarios plus hand-written
// corner sequences, with a scoreboard queue checking every delivered flit.
module tb_net_rx_packet_buffer;
    import net_rx_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_data;
    logic [7:0]  in_keep;
    logic        in_last;
    logic        out_valid;
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic        out_last;
    logic        out_ready;
    logic [15:0] drop_count;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } exp_t;

    typedef struct {
        int pkt_len;
        int pkt_num;
        int ready_mode;   // 0: always ready, 1: stalled while sending, 2: random
        int n_commit;
        int exp_drops;
    } vec_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   rmode = 0;
    int   seq   = 0;

    net_rx_packet_buffer #(.DEPTH(64), .MAX_PKTS(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_keep    (in_keep),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: scoreboard compare on handshakes, stability check on stalls.
    initial begin
        logic        stalled;
        logic [63:0] held_data;
        logic [9:0]  held_meta;
        exp_t        e;
        stalled = 1'b0;
        held_data = '0;
        held_meta = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_data", out_data, held_data);
                    check("stall_meta", {out_valid, out_last, out_keep}, held_meta);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_flit: got data %0h with nothing expected", out_data);
                    end else begin
                        e = sb.pop_front();
                        check("flit_data", out_data, e.data);
                        check("flit_keep", out_keep, e.keep);
                        check("flit_last", out_last, e.last);
                    end
                end
                stalled   = out_valid && !out_ready;
                held_data = out_data;
                held_meta = {out_valid, out_last, out_keep};
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rmode == 2) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        reset    = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_drop_count", drop_count, 0);
    endtask

    task automatic send_pkt(input int len, input bit commit);
        for (int i = 0; i < len; i++) begin
            exp_t e;
            seq++;
            e.data = {32'(seq), $urandom};
            e.keep = 8'($urandom);
            e.last = (i == len - 1);
            if (commit) sb.push_back(e);
            in_valid = 1'b1;
            in_data  = e.data;
            in_keep  = e.keep;
            in_last  = e.last;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({name, "_drained"}, sb.size(), 0);
        sb.delete();
        @(negedge clock);
        check({name, "_idle"}, out_valid, 0);
    endtask

    initial begin
        vec_t vecs[6];
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_keep   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{4, 1, 0, 1, 0};
        vecs[1] = '{1, 9, 1, 8, 1};
        vecs[2] = '{10, 1, 2, 1, 0};
        vecs[3] = '{13, 20, 0, 20, 0};
        vecs[4] = '{64, 1, 1, 1, 0};
        vecs[5] = '{5, 3, 2, 3, 0};

        // Commit latency: valid only in the cycle after the last flit is sampled.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            seq++;
            e.data = {32'(seq), $urandom};
            e.keep = 8'($urandom);
            e.last = (i == 3);
            sb.push_back(e);
            in_valid = 1'b1;
            in_data  = e.data;
            in_keep  = e.keep;
            in_last  = e.last;
            @(negedge clock);
            check("lat_pre_valid", out_valid, 0);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clock);
        check("lat_valid", out_valid, 1);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        drain("lat");
        check("lat_drop_count", drop_count, 0);

        foreach (vecs[v]) begin
            do_reset();
            rmode = vecs[v].ready_mode;
            if (rmode == 0) out_ready = 1'b1;
            if (rmode == 1) out_ready = 1'b0;
            for (int p = 0; p < vecs[v].pkt_num; p++) begin
                send_pkt(vecs[v].pkt_len, p < vecs[v].n_commit);
            end
            if (rmode == 1) out_ready = 1'b1;
            drain($sformatf("vec%0d", v));
            check($sformatf("vec%0d_drop_count", v), drop_count, 64'(vecs[v].exp_drops));
            rmode = 0;
            out_ready = 1'b1;
        end

        // Oversized packet dropped at flit 65, remainder discarded, next packet intact.
        do_reset();
        out_ready = 1'b0;
        send_pkt(70, 1'b0);
        check("big_drop_count", drop_count, 1);
        check("big_no_valid", out_valid, 0);
        send_pkt(3, 1'b1);
        out_ready = 1'b1;
        drain("big");
        check("big_drop_after", drop_count, 1);

        // A DEPTH-flit packet does not fit behind a committed one.
        do_reset();
        out_ready = 1'b0;
        send_pkt(1, 1'b1);
        send_pkt(64, 1'b0);
        check("full_drop_count", drop_count, 1);
        out_ready = 1'b1;
        drain("full");

        // Reset in the middle of a packet discards the partial packet.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = {32'hDEAD0000, 32'(i)};
            in_keep  = 8'hFF;
            in_last  = 1'b0;
            @(posedge clock);
            #1;
        end
        do_reset();
        repeat (3) @(posedge clock);
        #1;
        check("midrst_no_valid", out_valid, 0);
        send_pkt(2, 1'b1);
        drain("midrst");
        check("midrst_drop_count", drop_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/net_rx_packet_buffer.md
# net_rx_packet_buffer

Receive-side packet buffer between the simulated network endpoint's `net_in` stream and the NIC receive path. The network side has no backpressure, so it must be absorbed here. The block accepts one 64-bit flit per cycle and stores packets in a circular word buffer. A packet is exposed downstream only after its last flit arrives. A packet that does not fit, in word space or in packet slots, is dropped whole and counted.

## Interface
Parameters:
- `DEPTH`, 64: buffer capacity in flits; power of two, ≥ 4.
- `MAX_PKTS`, 8: maximum committed packets held; power of two, ≥ 2.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  flit present; there is no ready signal, so the flit must be taken or dropped this cycle.
- `in_data`  in  64  flit payload.
- `in_keep`  in  8  byte enables; stored and forwarded unchanged.
- `in_last`  in  1  final flit of the packet.
- `out_valid`  out  1  head flit of a committed packet is available.
- `out_data`  out  64  head flit payload.
- `out_keep`  out  8  head flit byte enables.
- `out_last`  out  1  head flit is the final flit of its packet.
- `out_ready`  in  1  consumer accepts the flit when `out_valid && out_ready`.
- `drop_count`  out  16  packets dropped since reset; saturates at 16'hFFFF.

## Operation
- Storage: `DEPTH` × 72-bit array holding {keep, data}.
- Pointers have width log2(DEPTH)+1, including a wrap bit:
  - `rd_ptr`: head of data.
  - `commit_ptr`: end of the last committed packet.
  - `wr_ptr`: speculative write position.
- Length FIFO: `MAX_PKTS` entries of log2(DEPTH)+1 bits, one per committed packet; `pkt_count` is its occupancy.
- Write FSM has two states:
  - **RECV**: in a packet or between packets.
  - **DROP**: discarding the remainder of a packet.
- Flit in RECV fits when both hold, evaluated on start-of-cycle values with no credit for a same-cycle read or pop:
  - `wr_ptr - rd_ptr < DEPTH`
  - `pkt_count < MAX_PKTS`
- Fitting flit: write the array at `wr_ptr`, then `wr_ptr++`, `cur_len++`.
  - If `in_last`: `commit_ptr <= wr_ptr+1`, push `cur_len+1` into the length FIFO, `cur_len <= 0`.
- Non-fitting flit:
  - Roll back: `wr_ptr <= commit_ptr`, `cur_len <= 0`.
  - Increment `drop_count` once, saturating.
  - If `in_last`, stay in RECV; otherwise go to DROP.
- DROP: discard every flit and do not increment `drop_count`. On `in_last`, return to RECV.
- Read side:
  - `out_valid = pkt_count != 0`.
  - `out_data`/`out_keep` come from the array at `rd_ptr`.
  - `out_last = (rd_cnt == len_head - 1)`.
- On an out handshake: `rd_ptr++`, `rd_cnt++`. If `out_last`, pop the length FIFO and set `rd_cnt <= 0`.
- Simultaneous push and pop: `pkt_count` is unchanged and both take effect.
- A packet of exactly `DEPTH` flits fits only when the buffer is otherwise empty.

## Timing
- Reset values:
  - `out_valid` = 0, `out_last` = 0, `drop_count` = 0.
  - `out_data`/`out_keep` are don't-care while `out_valid` = 0.
  - All pointers, `cur_len`, `rd_cnt` and `pkt_count` = 0; FSM = RECV.
- Reset mid-packet discards every partial and committed packet.
- Latency: last flit sampled at edge N → `out_valid` = 1 in the cycle after edge N. The first flit of that packet is at the head, or behind earlier committed packets.
- No combinational path from any `in_*` input, or from `out_ready`, to any output. Outputs depend only on registered state plus an asynchronous array read.
- `out_*` hold stable while `out_valid && !out_ready`.
- Throughput: one flit per cycle on each side concurrently.

## Structure
- Package `net_rx_pkg` holds:
  - `NET_IF_WIDTH` = 64, `NET_KEEP_WIDTH` = 8.
  - The FSM state enum {RECV, DROP}.
  - The stored-flit struct {keep, data}.
- Sub-module `net_rx_len_fifo`: a parameterised synchronous FIFO (width, depth) with push, pop, head, count and full outputs, used for the length queue.
- The data array and pointer logic stay in the top module.

## Test plan
- One 4-flit packet with `out_ready` = 1 → `out_valid` rises the cycle after its last flit; 4 flits are delivered in order with `out_last` on the 4th only; `drop_count` = 0.
- Defaults, `out_ready` = 0, a 70-flit packet, then a 3-flit packet → the first is dropped at flit 65 (`drop_count` = 1) and the rest is discarded; the 3-flit packet commits and drains correctly.
- `out_ready` = 0, nine 1-flit packets → 8 commit, the 9th is dropped (`drop_count` = 1); draining yields 8 flits, each with `out_last` = 1.
- A 10-flit packet with `out_ready` toggling pseudo-randomly → the payload is held stable during stalls; all 10 values arrive exactly once and in order.
- Twenty back-to-back 13-flit packets with `out_ready` = 1 → pointers wrap several times; all 260 flits arrive intact and `drop_count` = 0.
- 5 flits of a packet, then `reset` for 1 cycle, then a 2-flit packet → `out_valid` = 0 after reset; only the 2-flit packet is delivered.
